// File: rtl/bpb_update_ctrl.sv
// bpb_update_ctrl: in-order commit-update FIFO and clear sweeper driving the BPB write port (BPB_UPD_COALESCE_EN merges same-PC updates)
module bpb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int ENTRIES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       cm_valid,
  input  logic [1:0][31:0] cm_pc,
  input  logic [1:0]       cm_taken,
  input  logic [1:0][31:0] cm_target,
  input  logic             clear_req,
  output logic             bpb_wen,
  output logic [31:0]      bpb_pc,
  output logic             bpb_taken,
  output logic [31:0]      bpb_target,
  output logic             bpb_clr,
  output logic             busy,
  output logic             clear_done,
  output logic [7:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(ENTRIES);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_next;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] target_q [DEPTH];
  logic [DEPTH-1:0] taken_q;
  logic [AW:0] wr, rd, cnt;
  logic [AW-1:0] wm1, s0, s1;
  logic [IW-1:0] idx;
  logic full, empty, active, pop, v0, v1, c0, c1, c1s, acc0, acc1, push0, push1;
  logic [1:0] drops;
  logic [8:0] drop_sum;
  logic wen_d, clr_d, taken_d, done_d, busy_d;
  logic [31:0] pc_d, target_d;
  assign cnt = wr - rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign wm1 = wr[AW-1:0] - AW'(1);
  assign active = state == IDLE && !clear_req;
  assign pop = active && !stall && !empty;
  assign v0 = active && cm_valid[0];
  assign v1 = active && cm_valid[1];
`ifdef BPB_UPD_COALESCE_EN
  logic hit_ok;
  assign hit_ok = !empty && !(pop && int'(cnt) == 1);
  assign c0 = v0 && hit_ok && pc_q[wm1] == cm_pc[0];
  assign c1s = v0 && v1 && cm_pc[1] == cm_pc[0];
  assign c1 = c1s || (v1 && !v0 && hit_ok && pc_q[wm1] == cm_pc[1]);
`else
  assign c0 = 1'b0;
  assign c1 = 1'b0;
  assign c1s = 1'b0;
`endif
  assign acc0 = v0 && (c0 || !full);
  assign acc1 = v1 && (v0 ? acc0 && (c1s || (c0 ? !full : int'(cnt) <= DEPTH - 2)) : (c1 || !full));
  assign push0 = acc0 && !c0;
  assign push1 = acc1 && !c1;
  assign s0 = c0 ? wm1 : wr[AW-1:0];
  assign s1 = c1s ? s0 : c1 ? wm1 : wr[AW-1:0] + AW'(push0);
  assign drops = {1'b0, v0 && !acc0} + {1'b0, v1 && !acc1};
  assign drop_sum = {1'b0, drop_cnt} + {7'b0, drops};
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = clear_req ? CLEAR : (state == CLEAR && &idx) ? IDLE : state;
  end
  always_comb begin
    clr_d = state == CLEAR;
    wen_d = pop || clr_d;
    pc_d = clr_d ? 32'(idx) : pop ? pc_q[rd[AW-1:0]] : '0;
    taken_d = pop && taken_q[rd[AW-1:0]];
    target_d = pop ? target_q[rd[AW-1:0]] : '0;
    done_d = clr_d && &idx && !clear_req;
    busy_d = clr_d || state_next == CLEAR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      idx <= '0;
      drop_cnt <= '0;
      bpb_wen <= 1'b0;
      bpb_clr <= 1'b0;
      bpb_pc <= '0;
      bpb_taken <= 1'b0;
      bpb_target <= '0;
      busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      bpb_wen <= wen_d;
      bpb_clr <= clr_d;
      bpb_pc <= pc_d;
      bpb_taken <= taken_d;
      bpb_target <= target_d;
      busy <= busy_d;
      clear_done <= done_d;
      drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      idx <= (clr_d && !clear_req) ? idx + IW'(1) : '0;
      wr <= clear_req ? '0 : wr + {{AW{1'b0}}, push0} + {{AW{1'b0}}, push1};
      rd <= clear_req ? '0 : rd + {{AW{1'b0}}, pop};
      if (acc0) begin
        pc_q[s0] <= cm_pc[0];
        taken_q[s0] <= cm_taken[0];
        target_q[s0] <= cm_target[0];
      end
      if (acc1) begin
        pc_q[s1] <= cm_pc[1];
        taken_q[s1] <= cm_taken[1];
        target_q[s1] <= cm_target[1];
      end
    end
  end
endmodule

// File: tb/tb_bpb_update_ctrl.sv
// tb_bpb_update_ctrl: scoreboard bench for the BPB update controller
module tb_bpb_update_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic clear_req = 1'b0;
  logic [1:0] cm_valid = '0;
  logic [1:0] cm_taken = '0;
  logic [1:0][31:0] cm_pc = '0;
  logic [1:0][31:0] cm_target = '0;
  logic bpb_wen, bpb_taken, bpb_clr, busy, clear_done;
  logic [31:0] bpb_pc, bpb_target;
  logic [7:0] drop_cnt;
  int nvec = 0;
  int nerr = 0;
  int nw, ndone;
  logic found;
  logic [65:0] exp_q [$];
  logic [65:0] mon_e;
  always #5 clk = ~clk;
  bpb_update_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_taken(cm_taken), .cm_target(cm_target), .clear_req(clear_req),
    .bpb_wen(bpb_wen), .bpb_pc(bpb_pc), .bpb_taken(bpb_taken), .bpb_target(bpb_target),
    .bpb_clr(bpb_clr), .busy(busy), .clear_done(clear_done), .drop_cnt(drop_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_w(input logic [31:0] p, input logic t, input logic [31:0] g, input logic c);
    exp_q.push_back({c, t, p, g});
  endtask
  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] t, input logic [31:0] g0, input logic [31:0] g1);
    cm_valid = v;
    cm_pc[0] = p0;
    cm_pc[1] = p1;
    cm_taken = t;
    cm_target[0] = g0;
    cm_target[1] = g1;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask
  always @(negedge clk) begin
    if (bpb_wen === 1'b1) begin
      chk("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_pc", 64'(bpb_pc), 64'(mon_e[63:32]));
        chk("wr_attr", 64'({bpb_clr, bpb_taken, bpb_target}), 64'({mon_e[65:64], mon_e[31:0]}));
      end
    end
  end
  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_wen", 64'(bpb_wen), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(clear_done), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_pc", 64'(bpb_pc), 64'(0));
    reset = 1'b0;
    tick();
    drive(2'b01, 32'h80, 32'h0, 2'b01, 32'h100, 32'h0);
    exp_w(32'h80, 1'b1, 32'h100, 1'b0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("lat_c1", 64'(bpb_wen), 64'(0));
    @(negedge clk);
    chk("lat_c2", 64'(bpb_wen), 64'(1));
    stall = 1'b1;
    drive(2'b11, 32'h1000, 32'h1004, 2'b10, 32'h2000, 32'h2004);
    exp_w(32'h1000, 1'b0, 32'h2000, 1'b0);
    exp_w(32'h1004, 1'b1, 32'h2004, 1'b0);
    tick();
    drive(2'b11, 32'h1008, 32'h100c, 2'b01, 32'h2008, 32'h200c);
    exp_w(32'h1008, 1'b1, 32'h2008, 1'b0);
    exp_w(32'h100c, 1'b0, 32'h200c, 1'b0);
    tick();
    drive(2'b11, 32'h1010, 32'h1014, 2'b11, 32'h2010, 32'h2014);
    tick();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("full_drop", 64'(drop_cnt), 64'(2));
    chk("stall_hold", 64'(bpb_wen), 64'(0));
    stall = 1'b0;
    drain("drain_full");
    stall = 1'b1;
    drive(2'b10, 32'h0, 32'h3300, 2'b10, 32'h0, 32'h4300);
    exp_w(32'h3300, 1'b1, 32'h4300, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 32'h3000 + 32'(4 * i), 32'h0, 2'b00, 32'h4000 + 32'(i), 32'h0);
      exp_w(32'h3000 + 32'(4 * i), 1'b0, 32'h4000 + 32'(i), 1'b0);
      tick();
    end
    drive(2'b11, 32'h3100, 32'h3104, 2'b11, 32'h4100, 32'h4104);
    exp_w(32'h3100, 1'b1, 32'h4100, 1'b0);
    tick();
    drive(2'b10, 32'h0, 32'h3200, 2'b10, 32'h0, 32'h4200);
    tick();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("partial_drop", 64'(drop_cnt), 64'(4));
    stall = 1'b0;
    drain("drain_partial");
    stall = 1'b1;
    drive(2'b01, 32'h40, 32'h0, 2'b01, 32'h500, 32'h0);
    tick();
    drive(2'b01, 32'h40, 32'h0, 2'b00, 32'h600, 32'h0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
`ifdef BPB_UPD_COALESCE_EN
    exp_w(32'h40, 1'b0, 32'h600, 1'b0);
`else
    exp_w(32'h40, 1'b1, 32'h500, 1'b0);
    exp_w(32'h40, 1'b0, 32'h600, 1'b0);
`endif
    stall = 1'b0;
    drain("drain_coal");
    stall = 1'b1;
    drive(2'b11, 32'h7000, 32'h7004, 2'b11, 32'h7100, 32'h7104);
    tick();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 64; i++) exp_w(32'(i), 1'b0, 32'h0, 1'b1);
    drive(2'b11, 32'h7200, 32'h7204, 2'b11, 32'h0, 32'h0);
    @(negedge clk);
    chk("clr_busy_on", 64'(busy), 64'(1));
    nw = 0;
    ndone = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 10) drive(2'b00, 0, 0, 2'b00, 0, 0);
      if (bpb_wen && bpb_clr) nw++;
      if (clear_done) ndone++;
      if (i == 63) begin
        chk("clr_done_63", 64'(clear_done), 64'(1));
        chk("clr_busy_63", 64'(busy), 64'(1));
      end
    end
    chk("clr_len", 64'(nw), 64'(64));
    chk("clr_done_cnt", 64'(ndone), 64'(1));
    @(negedge clk);
    chk("clr_busy_off", 64'(busy), 64'(0));
    chk("clr_done_off", 64'(clear_done), 64'(0));
    chk("clr_wen_off", 64'(bpb_wen), 64'(0));
    chk("clr_nodrop", 64'(drop_cnt), 64'(4));
    drain("drain_clr");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i <= 20; i++) exp_w(32'(i), 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 64; i++) exp_w(32'(i), 1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bpb_wen && bpb_pc == 32'd19) found = 1'b1;
    end
    chk("rs_reach", 64'(found), 64'(1));
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    nw = 0;
    ndone = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bpb_wen && bpb_clr) nw++;
      if (clear_done) ndone++;
      if (i == 63) chk("rs_done_63", 64'(clear_done), 64'(1));
    end
    chk("rs_len", 64'(nw), 64'(64));
    chk("rs_done_cnt", 64'(ndone), 64'(1));
    @(negedge clk);
    chk("rs_busy_off", 64'(busy), 64'(0));
    drain("drain_rs");
    stall = 1'b1;
    for (int i = 0; i < 130; i++) begin
      drive(2'b11, 32'h5000 + 32'(8 * i), 32'h5004 + 32'(8 * i), 2'b01, 32'(i), 32'(i + 1000));
      if (i < 2) begin
        exp_w(32'h5000 + 32'(8 * i), 1'b1, 32'(i), 1'b0);
        exp_w(32'h5004 + 32'(8 * i), 1'b0, 32'(i + 1000), 1'b0);
      end
      tick();
    end
    drive(2'b00, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("drop_sat", 64'(drop_cnt), 64'(255));
    stall = 1'b0;
    drain("drain_sat");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) exp_w(32'(i), 1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bpb_wen && bpb_pc == 32'd9) found = 1'b1;
    end
    chk("rm_reach", 64'(found), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("rm_wen", 64'(bpb_wen), 64'(0));
    chk("rm_busy", 64'(busy), 64'(0));
    chk("rm_done", 64'(clear_done), 64'(0));
    chk("rm_drop", 64'(drop_cnt), 64'(0));
    reset = 1'b0;
    nw = 0;
    ndone = 0;
    repeat (70) begin
      @(negedge clk);
      if (bpb_wen) nw++;
      if (clear_done) ndone++;
    end
    chk("rm_nodone", 64'(ndone), 64'(0));
    chk("rm_nowen", 64'(nw), 64'(0));
    chk("final_q", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
